mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max cycles in a busy state awaiting mem_ack before forced completion (range 2..255).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch request; held with if_addr stable until if_ready.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_kill  input  1  flush; discards current or in-flight fetch.
REQ-007 if_ready  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetch data; valid only while if_ready=1.
REQ-009 dm_req  input  1  data request; dm_we/dm_size/dm_addr/dm_wdata held stable until dm_ready.
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_size  input  2  access size, passed through unchanged.
REQ-012 dm_addr, dm_wdata  input  32 each  data address, store data.
REQ-013 dm_ready  output  1  one-cycle data completion pulse.
REQ-014 dm_rdata  output  32  load data; valid only while dm_ready=1.
REQ-015 mem_req, mem_we  output  1 each  shared-port request, write enable.
REQ-016 mem_size  output  2; mem_addr, mem_wdata  output  32 each  latched command.
REQ-017 mem_rdata  input  32; mem_ack  input  1  one-cycle completion, data valid with ack.
REQ-018 err  output  1  one-cycle timeout pulse, coincident with the forced ready.
REQ-019 stall_if, stall_mem  output  1 each  combinational: if_req&~if_ready, dm_req&~dm_ready.

Function
REQ-020 FSM states: IDLE, BUSY_I, BUSY_D, BUSY_IK (fetch killed, awaiting ack).
REQ-021 IDLE grant, with data having priority: dm_req (eligible) -> BUSY_D; else if_req (eligible) and not if_kill -> BUSY_I; else stay.
REQ-022 A side is ineligible for grant in any cycle its own ready output is 1, so a requester's trailing req is never regranted.
REQ-023 On grant edge, latch mem_addr/mem_we/mem_size/mem_wdata from the granted side; fetch latches mem_we=0, mem_size=2'b10, mem_wdata=0.
REQ-024 mem_req=1 exactly in BUSY_I, BUSY_D and BUSY_IK; mem_* command fields constant throughout.
REQ-025 mem_ack sampled in busy cycle M -> state IDLE at M+1; ready/rdata registered, pulsed in cycle M+1 for the owning side only.
REQ-026 Minimum latency: req in IDLE cycle N, ack in N+1 -> ready in N+2; back-to-back grant earliest at N+2, mem_req again at N+3.
REQ-027 if_kill in BUSY_I -> BUSY_IK; kill in BUSY_I coincident with mem_ack -> IDLE with no if_ready.
REQ-028 BUSY_IK + mem_ack -> IDLE, no if_ready and no err; if_kill does not affect BUSY_D or a data grant.
REQ-029 mem_ack in IDLE is ignored.
REQ-030 Timeout counter clears on grant and increments each busy cycle without ack; when it reaches TIMEOUT-1 without ack -> IDLE next cycle, owner ready pulsed with rdata=0 and err=1; BUSY_IK timeout gives err=1 only.
REQ-031 Ack in the same cycle the count reaches TIMEOUT-1 is a normal completion, err=0.
REQ-032 if_rdata/dm_rdata are 0 whenever the corresponding ready is 0.

Reset
REQ-033 reset=1 at a clock edge -> IDLE, counter 0; mem_req, mem_we, if_ready, dm_ready, err = 0; mem_addr, mem_wdata, mem_size, if_rdata, dm_rdata = 0 from next cycle.
REQ-034 Reset mid-transaction abandons it, with no ready or err pulse; an ack after reset is ignored by REQ-029.

Verification
REQ-035 Fetch: if_req, if_addr=0x10000 in IDLE; ack with mem_rdata=0x00000013 one cycle after mem_req -> if_ready, if_rdata=0x13 two cycles after the req cycle.
REQ-036 Conflict: if_req and dm_req (store, addr 0x2000, wdata 0xDEADBEEF) in the same IDLE cycle -> store granted first with mem_we=1; fetch granted in the cycle dm_ready pulses.
REQ-037 Kill: if_kill during BUSY_I, ack two cycles later -> no if_ready, mem_req held until ack, next if_req granted normally.
REQ-038 Timeout: with TIMEOUT=4, dm load with no ack -> dm_ready=1, dm_rdata=0, err=1 in the same cycle, exactly 4 busy cycles after the grant.
REQ-039 Reset while in BUSY_D -> next cycle mem_req=0, no dm_ready; a late mem_ack produces no output.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// Data wins ties. A stuck access is forced to finish after TIMEOUT busy cycles.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err,
    output logic        stall_if,
    output logic        stall_mem
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, BUSY_IK} state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic        r_if_ready;
    logic        r_dm_ready;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_err;
    logic        r_mem_we;
    logic [1:0]  r_mem_size;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic w_busy;
    logic w_timeout;
    logic w_dm_elig;
    logic w_if_elig;
    logic w_grant_d;
    logic w_grant_i;

    // A side whose ready is high this cycle is showing a trailing req, not a new one.
    assign w_dm_elig = dm_req & ~r_dm_ready;
    assign w_if_elig = if_req & ~r_if_ready & ~if_kill;
    assign w_busy    = (r_state != IDLE);
    assign w_timeout = w_busy & ~mem_ack & (r_cnt == LP_LAST);
    assign w_grant_d = (r_state == IDLE) & w_dm_elig;
    assign w_grant_i = (r_state == IDLE) & ~w_dm_elig & w_if_elig;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next = BUSY_D;
                end else if (w_grant_i) begin
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = IDLE;
                end else if (if_kill) begin
                    w_state_next = BUSY_IK;
                end
            end
            BUSY_D, BUSY_IK: begin
                if (mem_ack || w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        case (r_state)
            BUSY_I, BUSY_D, BUSY_IK: mem_req = 1'b1;
            default:                 mem_req = 1'b0;
        endcase
    end

    // Completion pulses default low each cycle; a kill in the completing cycle suppresses the fetch pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_size  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_err      <= 1'b0;
            if (w_grant_d) begin
                r_mem_we    <= dm_we;
                r_mem_size  <= dm_size;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
                r_cnt       <= '0;
            end else if (w_grant_i) begin
                r_mem_we    <= 1'b0;
                r_mem_size  <= 2'b10;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
                r_cnt       <= '0;
            end else if (w_busy) begin
                if (mem_ack) begin
                    if (r_state == BUSY_D) begin
                        r_dm_ready <= 1'b1;
                        r_dm_rdata <= mem_rdata;
                    end else if (r_state == BUSY_I && !if_kill) begin
                        r_if_ready <= 1'b1;
                        r_if_rdata <= mem_rdata;
                    end
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                    if (r_state == BUSY_D) begin
                        r_dm_ready <= 1'b1;
                    end else if (r_state == BUSY_I && !if_kill) begin
                        r_if_ready <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign dm_ready  = r_dm_ready;
    assign dm_rdata  = r_dm_rdata;
    assign err       = r_err;
    assign mem_we    = r_mem_we;
    assign mem_size  = r_mem_size;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall_if  = if_req & ~r_if_ready;
    assign stall_mem = dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter (TIMEOUT=4): cycle table plus completion scoreboard,
// then hand sequences for timeout, ack at the last count, killed timeout and reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ready;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ack, err, stall_if, stall_mem;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] SB_ERR  = 2'b00;
    localparam logic [1:0] SB_IF   = 2'b01;
    localparam logic [1:0] SB_DM   = 2'b10;
    localparam logic [1:0] SB_NONE = 2'b11;
    localparam logic        N = 1'b0;
    localparam logic        Y = 1'b1;
    localparam logic [31:0] Z = 32'h0;

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        ikill;
        logic        dreq;
        logic        dwe;
        logic [1:0]  dsz;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        mack;
        logic [31:0] mrdata;
        logic        e_mreq;
        logic        e_mwe;
        logic [1:0]  e_msz;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_ir;
        logic        e_dr;
        logic [1:0]  sb;
    } vec_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic        err;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check();
        sb_t e;
        if (if_ready !== 1'b1) chk("if_rdata_when_not_ready", if_rdata, Z);
        if (dm_ready !== 1'b1) chk("dm_rdata_when_not_ready", dm_rdata, Z);
        if (if_ready === 1'b1 || dm_ready === 1'b1 || err === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got if_ready=%b dm_ready=%b err=%b expected no completion",
                         if_ready, dm_ready, err);
            end else begin
                e = sb_q.pop_front();
                chk("sb_side", {30'h0, dm_ready, if_ready}, {30'h0, e.kind});
                chk("sb_rdata", if_ready ? if_rdata : dm_rdata, e.data);
                chk("sb_err", {31'h0, err}, {31'h0, e.err});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = Z; if_kill = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = Z; dm_wdata = Z;
        mem_ack = 1'b0; mem_rdata = Z;
    endtask

    task automatic drive(input vec_t v);
        if_req = v.ireq; if_addr = v.iaddr; if_kill = v.ikill;
        dm_req = v.dreq; dm_we = v.dwe; dm_size = v.dsz; dm_addr = v.daddr; dm_wdata = v.dwdata;
        mem_ack = v.mack; mem_rdata = v.mrdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   busy;
        int   n;
        logic got;

        // ireq iaddr ikill dreq dwe dsz daddr dwdata mack mrdata | mreq mwe msz maddr mwdata ir dr | sb
        tbl[0]  = '{Y, 32'h10000, N, N, N, 2'b00, Z, Z, N, Z,            N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[1]  = '{Y, 32'h10000, N, N, N, 2'b00, Z, Z, Y, 32'h13,       Y, N, 2'b10, 32'h10000, Z, N, N, SB_IF};
        tbl[2]  = '{Y, 32'h10000, N, N, N, 2'b00, Z, Z, N, Z,            N, N, 2'b00, Z, Z, Y, N, SB_NONE};
        tbl[3]  = '{N, Z, N, N, N, 2'b00, Z, Z, N, Z,                    N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[4]  = '{Y, 32'h400, N, Y, Y, 2'b10, 32'h2000, 32'hDEADBEEF, N, Z, N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[5]  = '{Y, 32'h400, N, Y, Y, 2'b10, 32'h2000, 32'hDEADBEEF, N, Z, Y, Y, 2'b10, 32'h2000, 32'hDEADBEEF, N, N, SB_NONE};
        tbl[6]  = '{Y, 32'h400, N, Y, Y, 2'b10, 32'h2000, 32'hDEADBEEF, Y, Z, Y, Y, 2'b10, 32'h2000, 32'hDEADBEEF, N, N, SB_DM};
        tbl[7]  = '{Y, 32'h400, N, Y, Y, 2'b10, 32'h2000, 32'hDEADBEEF, N, Z, N, N, 2'b00, Z, Z, N, Y, SB_NONE};
        tbl[8]  = '{Y, 32'h400, N, N, N, 2'b00, Z, Z, Y, 32'hA5A5A5A5,  Y, N, 2'b10, 32'h400, Z, N, N, SB_IF};
        tbl[9]  = '{Y, 32'h400, N, N, N, 2'b00, Z, Z, N, Z,              N, N, 2'b00, Z, Z, Y, N, SB_NONE};
        tbl[10] = '{N, Z, N, N, N, 2'b00, Z, Z, N, Z,                    N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[11] = '{Y, 32'h800, N, N, N, 2'b00, Z, Z, N, Z,              N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[12] = '{Y, 32'h800, Y, N, N, 2'b00, Z, Z, N, Z,              Y, N, 2'b10, 32'h800, Z, N, N, SB_NONE};
        tbl[13] = '{N, Z, N, N, N, 2'b00, Z, Z, N, Z,                    Y, N, 2'b10, 32'h800, Z, N, N, SB_NONE};
        tbl[14] = '{N, Z, N, N, N, 2'b00, Z, Z, Y, 32'hBAD,              Y, N, 2'b10, 32'h800, Z, N, N, SB_NONE};
        tbl[15] = '{N, Z, N, N, N, 2'b00, Z, Z, Y, 32'h77,               N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[16] = '{N, Z, N, N, N, 2'b00, Z, Z, N, Z,                    N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[17] = '{Y, 32'hC00, N, N, N, 2'b00, Z, Z, N, Z,              N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[18] = '{Y, 32'hC00, N, N, N, 2'b00, Z, Z, Y, 32'h1234,       Y, N, 2'b10, 32'hC00, Z, N, N, SB_IF};
        tbl[19] = '{N, Z, N, N, N, 2'b00, Z, Z, N, Z,                    N, N, 2'b00, Z, Z, Y, N, SB_NONE};
        tbl[20] = '{Y, 32'h900, N, N, N, 2'b00, Z, Z, N, Z,              N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[21] = '{Y, 32'h900, Y, N, N, 2'b00, Z, Z, Y, 32'h99,         Y, N, 2'b10, 32'h900, Z, N, N, SB_NONE};
        tbl[22] = '{Y, 32'h900, Y, N, N, 2'b00, Z, Z, N, Z,              N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[23] = '{N, Z, N, N, N, 2'b00, Z, Z, N, Z,                    N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[24] = '{N, Z, Y, Y, N, 2'b00, 32'h3000, Z, N, Z,             N, N, 2'b00, Z, Z, N, N, SB_NONE};
        tbl[25] = '{N, Z, Y, Y, N, 2'b00, 32'h3000, Z, Y, 32'hCAFEF00D,  Y, N, 2'b00, 32'h3000, Z, N, N, SB_DM};
        tbl[26] = '{N, Z, N, Y, N, 2'b00, 32'h3000, Z, N, Z,             N, N, 2'b00, Z, Z, N, Y, SB_NONE};
        tbl[27] = '{N, Z, N, N, N, 2'b00, Z, Z, N, Z,                    N, N, 2'b00, Z, Z, N, N, SB_NONE};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_mem_req", {31'h0, mem_req}, Z);
        chk("rst_mem_we", {31'h0, mem_we}, Z);
        chk("rst_if_ready", {31'h0, if_ready}, Z);
        chk("rst_dm_ready", {31'h0, dm_ready}, Z);
        chk("rst_err", {31'h0, err}, Z);
        chk("rst_mem_addr", mem_addr, Z);
        chk("rst_mem_wdata", mem_wdata, Z);
        chk("rst_mem_size", {30'h0, mem_size}, Z);
        reset = 1'b0;

        for (int k = 0; k < 28; k++) begin
            v = tbl[k];
            chk($sformatf("row%0d_mem_req", k), {31'h0, mem_req}, {31'h0, v.e_mreq});
            if (v.e_mreq) begin
                chk($sformatf("row%0d_mem_we", k), {31'h0, mem_we}, {31'h0, v.e_mwe});
                chk($sformatf("row%0d_mem_size", k), {30'h0, mem_size}, {30'h0, v.e_msz});
                chk($sformatf("row%0d_mem_addr", k), mem_addr, v.e_maddr);
                chk($sformatf("row%0d_mem_wdata", k), mem_wdata, v.e_mwdata);
            end
            chk($sformatf("row%0d_if_ready", k), {31'h0, if_ready}, {31'h0, v.e_ir});
            chk($sformatf("row%0d_dm_ready", k), {31'h0, dm_ready}, {31'h0, v.e_dr});
            chk($sformatf("row%0d_err", k), {31'h0, err}, Z);
            drive(v);
            if (v.sb != SB_NONE) sb_q.push_back('{v.sb, v.mrdata, 1'b0});
            #1;
            chk($sformatf("row%0d_stall_if", k), {31'h0, stall_if}, {31'h0, v.ireq & ~v.e_ir});
            chk($sformatf("row%0d_stall_mem", k), {31'h0, stall_mem}, {31'h0, v.dreq & ~v.e_dr});
            tick();
        end

        // Load with no ack: forced completion after exactly 4 busy cycles.
        idle_inputs();
        dm_req = 1'b1; dm_addr = 32'h4000;
        sb_q.push_back('{SB_DM, 32'h0, 1'b1});
        busy = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (dm_ready === 1'b1) got = 1'b1;
            else if (mem_req === 1'b1) busy++;
        end
        chk("timeout_seen", {31'h0, got}, 32'h1);
        chk("timeout_busy_cycles", busy, 32'd4);
        dm_req = 1'b0;
        tick();
        chk("timeout_after_err", {31'h0, err}, Z);

        // Ack on the last counted cycle is a normal completion.
        if_req = 1'b1; if_addr = 32'h5000;
        tick(); tick(); tick(); tick();
        chk("lastcnt_mem_req", {31'h0, mem_req}, 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h31;
        sb_q.push_back('{SB_IF, 32'h31, 1'b0});
        tick();
        chk("lastcnt_if_ready", {31'h0, if_ready}, 32'h1);
        chk("lastcnt_err", {31'h0, err}, Z);
        idle_inputs();
        tick();

        // Killed fetch that never gets an ack: err alone, no if_ready.
        if_req = 1'b1; if_addr = 32'h6000;
        tick();
        if_kill = 1'b1; if_req = 1'b0;
        tick();
        if_kill = 1'b0;
        sb_q.push_back('{SB_ERR, 32'h0, 1'b1});
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            n++;
            if (err === 1'b1) got = 1'b1;
        end
        chk("ik_timeout_seen", {31'h0, got}, 32'h1);
        chk("ik_timeout_cycles", n, 32'd3);
        tick();

        // Reset mid data access, then a stray ack.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h7000; dm_wdata = 32'h11;
        tick();
        chk("rstmid_busy", {31'h0, mem_req}, 32'h1);
        reset = 1'b1; dm_req = 1'b0;
        tick();
        reset = 1'b0;
        chk("rstmid_mem_req", {31'h0, mem_req}, Z);
        chk("rstmid_dm_ready", {31'h0, dm_ready}, Z);
        chk("rstmid_err", {31'h0, err}, Z);
        chk("rstmid_mem_addr", mem_addr, Z);
        chk("rstmid_mem_wdata", mem_wdata, Z);
        mem_ack = 1'b1; mem_rdata = 32'hFF;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("late_ack_dm_ready", {31'h0, dm_ready}, Z);
        chk("late_ack_mem_req", {31'h0, mem_req}, Z);
        chk("sb_leftover", sb_q.size(), Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
